// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg: shared types and constants for the LCD1602 emulator.
// Holds opcode masks, DDRAM wrap points, fill constants and FSM states.
package lcd1602_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    typedef struct packed {
        logic disp_on;
        logic cursor_on;
        logic blink_on;
        logic id;
        logic sh;
        logic dl;
        logic n_lines;
        logic font;
    } mode_t;

    localparam mode_t MODE_RST = '{
        disp_on: 1'b0, cursor_on: 1'b0, blink_on: 1'b0, id: 1'b1,
        sh: 1'b0, dl: 1'b1, n_lines: 1'b0, font: 1'b0
    };

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [6:0] AC_L1_LAST = 7'h27;
    localparam logic [6:0] AC_L2_BASE = 7'h40;
    localparam logic [6:0] AC_L2_LAST = 7'h67;
    localparam logic [6:0] AC_L2_OFS  = 7'h18;
    localparam logic [7:0] FILL_CHAR  = 8'h20;
    localparam int         DDRAM_DEPTH = 80;
    localparam logic [6:0] FILL_END   = 7'(DDRAM_DEPTH);

    // Line 2 (0x40..0x67) packs directly after line 1 (0x00..0x27).
    function automatic logic [6:0] ddram_idx(input logic [6:0] ac);
        return (ac < AC_L2_BASE) ? ac : ac - AC_L2_OFS;
    endfunction

    // Out-of-line set-address values fold onto the start of that line.
    function automatic logic [6:0] ddram_fold(input logic [6:0] a);
        if (a >= 7'h68)
            return AC_L2_BASE;
        if (a >= 7'h28 && a < AC_L2_BASE)
            return 7'h00;
        return a;
    endfunction

    function automatic logic [6:0] ac_step(
        input logic [6:0] ac,
        input logic       cg,
        input logic       inc
    );
        logic [5:0] low;
        low = inc ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1;
        if (cg)
            return {1'b0, low};
        if (inc) begin
            if (ac == AC_L1_LAST)
                return AC_L2_BASE;
            if (ac == AC_L2_LAST)
                return 7'h00;
            return ac + 7'd1;
        end
        if (ac == 7'h00)
            return AC_L2_LAST;
        if (ac == AC_L2_BASE)
            return AC_L1_LAST;
        return ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd1602_ddram.sv
// lcd1602_ddram: 80-byte display data RAM, no reset (contents survive rst_n).
// Ports: we/waddr/wdata write; baddr->bdata comb bus read; raddr->rdata registered.
module lcd1602_ddram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] baddr,
    output logic [7:0] bdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);
    import lcd1602_pkg::*;

    logic [7:0] mem [DDRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we && waddr < FILL_END)
            mem[waddr] <= wdata;
        // write-first so a same-cycle write is visible on the next rdata
        if (we && waddr == raddr)
            rdata <= wdata;
        else
            rdata <= mem[raddr];
    end

    assign bdata = mem[baddr];

endmodule

// File: rtl/lcd1602_emu.sv
// lcd1602_emu: HD44780-style LCD1602 bus emulator (instruction decode, AC, BF).
// Ports: clk, rst_n (sync low), rs/rw/en/db_i host bus, db_o/db_oe read data,
// rd_addr/rd_data screen port, mode bits, err_busy. Macro LCD1602_CGRAM_EN adds CGRAM.
module lcd1602_emu #(
    parameter int BUSY_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] db_i,
    output logic [7:0] db_o,
    output logic       db_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       id,
    output logic       sh,
    output logic       dl,
    output logic       n_lines,
    output logic       font,
    output logic       err_busy
);
    import lcd1602_pkg::*;

    localparam int CW = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_CYC - 1);

    logic          en_q, rs_q, rw_q;
    logic [7:0]    db_q;
    state_t        state, state_nxt;
    logic [CW-1:0] busy_cnt, busy_cnt_nxt;
    logic [6:0]    fill_idx, fill_idx_nxt;
    logic [6:0]    ac, ac_nxt;
    logic          ac_cg, ac_cg_nxt;
    mode_t         mode, mode_nxt;
    logic          err_nxt;

    logic          strobe, idle, wr_stb, wr_ok, rd_stb;
    logic          mem_we;
    logic [6:0]    mem_waddr;
    logic [7:0]    mem_wdata;
    logic [7:0]    bus_rdata, cg_rdata;
    logic [6:0]    rd_idx;

    assign strobe = en_q & ~en;
    assign idle   = (state == ST_IDLE);
    assign wr_stb = strobe & ~rw_q;
    assign rd_stb = strobe & rw_q;
    assign wr_ok  = wr_stb & idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            db_q     <= 8'h00;
            state    <= ST_IDLE;
            busy_cnt <= '0;
            fill_idx <= '0;
            ac       <= 7'h00;
            ac_cg    <= 1'b0;
            mode     <= MODE_RST;
            err_busy <= 1'b0;
        end else begin
            en_q     <= en;
            rs_q     <= rs;
            rw_q     <= rw;
            db_q     <= db_i;
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            fill_idx <= fill_idx_nxt;
            ac       <= ac_nxt;
            ac_cg    <= ac_cg_nxt;
            mode     <= mode_nxt;
            err_busy <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        fill_idx_nxt = fill_idx;
        ac_nxt       = ac;
        ac_cg_nxt    = ac_cg;
        mode_nxt     = mode;
        err_nxt      = err_busy | (wr_stb & ~idle);
        mem_we       = 1'b0;
        mem_waddr    = ddram_idx(ac);
        mem_wdata    = db_q;

        unique case (state)
            ST_IDLE: begin
                if (wr_ok) begin
                    state_nxt = (!rs_q && db_q == OP_CLEAR) ? ST_CLEAR : ST_BUSY;
                    busy_cnt_nxt = '0;
                    fill_idx_nxt = '0;
                end
            end
            ST_CLEAR: begin
                // one extra cycle after the last fill before BUSY starts
                if (fill_idx == FILL_END) begin
                    state_nxt    = ST_BUSY;
                    busy_cnt_nxt = '0;
                end else begin
                    mem_we       = 1'b1;
                    mem_waddr    = fill_idx;
                    mem_wdata    = FILL_CHAR;
                    fill_idx_nxt = fill_idx + 7'd1;
                end
            end
            ST_BUSY: begin
                if (busy_cnt == BUSY_LAST)
                    state_nxt = ST_IDLE;
                else
                    busy_cnt_nxt = busy_cnt + 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (wr_ok && rs_q) begin
            if (!ac_cg)
                mem_we = 1'b1;
            ac_nxt = ac_step(ac, ac_cg, mode.id);
        end else if (wr_ok) begin
            priority case (1'b1)
                |(db_q & OP_DDRAM): begin
                    ac_nxt    = ddram_fold(db_q[6:0]);
                    ac_cg_nxt = 1'b0;
                end
                |(db_q & OP_CGRAM): begin
                    ac_nxt    = {1'b0, db_q[5:0]};
                    ac_cg_nxt = 1'b1;
                end
                |(db_q & OP_FUNC): begin
                    mode_nxt.dl      = db_q[4];
                    mode_nxt.n_lines = db_q[3];
                    mode_nxt.font    = db_q[2];
                end
                |(db_q & OP_SHIFT): begin
                    if (!db_q[3])
                        ac_nxt = ac_step(ac, ac_cg, db_q[2]);
                end
                |(db_q & OP_DISP): begin
                    mode_nxt.disp_on   = db_q[2];
                    mode_nxt.cursor_on = db_q[1];
                    mode_nxt.blink_on  = db_q[0];
                end
                |(db_q & OP_ENTRY): begin
                    mode_nxt.id = db_q[1];
                    mode_nxt.sh = db_q[0];
                end
                |(db_q & OP_HOME): begin
                    ac_nxt    = 7'h00;
                    ac_cg_nxt = 1'b0;
                end
                |(db_q & OP_CLEAR): begin
                    ac_nxt      = 7'h00;
                    ac_cg_nxt   = 1'b0;
                    mode_nxt.id = 1'b1;
                end
                default: ;
            endcase
        end else if (rd_stb && rs_q) begin
            ac_nxt = ac_step(ac, ac_cg, mode.id);
        end
    end

`ifdef LCD1602_CGRAM_EN
    logic [7:0] cgram [64];

    always_ff @(posedge clk) begin
        if (rst_n && wr_ok && rs_q && ac_cg)
            cgram[ac[5:0]] <= db_q;
    end

    assign cg_rdata = cgram[ac[5:0]];
`else
    assign cg_rdata = 8'h00;
`endif

    // screen row 1 (rd_addr[4]) sits at DDRAM 0x40
    assign rd_idx = ddram_idx({rd_addr[4], 2'b00, rd_addr[3:0]});

    lcd1602_ddram u_ddram (
        .clk   (clk),
        .we    (mem_we & rst_n),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .baddr (ddram_idx(ac)),
        .bdata (bus_rdata),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_comb begin
        db_o = {~idle, ac};
        if (rs)
            db_o = ac_cg ? cg_rdata : bus_rdata;
    end

    assign db_oe = rst_n & en & rw;

    assign disp_on   = mode.disp_on;
    assign cursor_on = mode.cursor_on;
    assign blink_on  = mode.blink_on;
    assign id        = mode.id;
    assign sh        = mode.sh;
    assign dl        = mode.dl;
    assign n_lines   = mode.n_lines;
    assign font      = mode.font;

endmodule

// File: tb/tb_lcd1602_emu.sv
// tb_lcd1602_emu: randomized bus traffic checked against an address-level
// model of the LCD1602 (DDRAM by address, AC as a linear screen position).
module tb_lcd1602_emu;

    logic       clk = 1'b0;
    logic       rst_n, rs, rw, en;
    logic [7:0] db_i, db_o, rd_data;
    logic       db_oe;
    logic [4:0] rd_addr;
    logic       disp_on, cursor_on, blink_on, id, sh, dl, n_lines, font;
    logic       err_busy;

    lcd1602_emu #(.BUSY_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rw(rw), .en(en),
        .db_i(db_i), .db_o(db_o), .db_oe(db_oe),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .id(id), .sh(sh), .dl(dl), .n_lines(n_lines), .font(font),
        .err_busy(err_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model
    logic [7:0] m_dd [128];
    bit         m_dd_ok [128];
    logic [7:0] m_cg [64];
    bit         m_cg_ok [64];
    int         m_ac;
    bit         m_cgsel;
    bit m_disp, m_cur, m_blink, m_id, m_sh, m_dl, m_n, m_font, m_err;

    function automatic logic [7:0] m_mode();
        return {m_disp, m_cur, m_blink, m_id, m_sh, m_dl, m_n, m_font};
    endfunction

    function automatic logic [7:0] dut_mode();
        return {disp_on, cursor_on, blink_on, id, sh, dl, n_lines, font};
    endfunction

    task automatic m_reset();
        m_ac = 0; m_cgsel = 0; m_err = 0;
        {m_disp, m_cur, m_blink, m_id, m_sh, m_dl, m_n, m_font} = 8'b0001_0100;
    endtask

    // AC walks a ring of 80 screen positions; line 2 starts at 0x40
    task automatic m_step(input bit inc);
        int p;
        if (m_cgsel) begin
            m_ac = (m_ac + (inc ? 1 : 63)) % 64;
        end else begin
            p = (m_ac < 'h40) ? m_ac : m_ac - 'h40 + 40;
            p = (p + (inc ? 1 : 79)) % 80;
            m_ac = (p < 40) ? p : p - 40 + 'h40;
        end
    endtask

    task automatic m_instr(input logic [7:0] d);
        int a;
        if (d >= 8'h80) begin
            a = d - 'h80;
            if (a >= 'h28 && a < 'h40) a = 0;
            else if (a >= 'h68) a = 'h40;
            m_ac = a; m_cgsel = 0;
        end else if (d >= 8'h40) begin
            m_ac = d - 'h40; m_cgsel = 1;
        end else if (d >= 8'h20) begin
            {m_dl, m_n, m_font} = d[4:2];
        end else if (d >= 8'h10) begin
            if (!d[3]) m_step(d[2]);
        end else if (d >= 8'h08) begin
            {m_disp, m_cur, m_blink} = d[2:0];
        end else if (d >= 8'h04) begin
            {m_id, m_sh} = d[1:0];
        end else if (d >= 8'h02) begin
            m_ac = 0; m_cgsel = 0;
        end else if (d == 8'h01) begin
            m_ac = 0; m_cgsel = 0; m_id = 1;
            for (int k = 0; k < 'h68; k++)
                if (k < 'h28 || k >= 'h40) begin
                    m_dd[k] = 8'h20; m_dd_ok[k] = 1;
                end
        end
    endtask

    task automatic m_data_wr(input logic [7:0] d);
        if (m_cgsel) begin
`ifdef LCD1602_CGRAM_EN
            m_cg[m_ac] = d; m_cg_ok[m_ac] = 1;
`endif
        end else begin
            m_dd[m_ac] = d; m_dd_ok[m_ac] = 1;
        end
        m_step(m_id);
    endtask

    // bus primitives
    task automatic bus_write(input logic r, input logic [7:0] d);
        @(negedge clk); rs = r; rw = 0; db_i = d; en = 1;
        @(negedge clk); en = 0;
        @(posedge clk);
    endtask

    task automatic bus_read(input logic r, output logic [7:0] d);
        @(negedge clk); rs = r; rw = 1; en = 1;
        #1 d = db_o;
        check("db_oe_read", db_oe, 1);
        @(negedge clk); en = 0; rw = 0;
        @(posedge clk);
    endtask

    // holds a BF poll, counts cycles with BF=1, returns AC seen when idle
    task automatic wait_idle(output int n, output logic [6:0] a);
        n = 0;
        @(negedge clk); rs = 0; rw = 1; en = 1;
        #1;
        while (db_o[7] && n < 300) begin
            n++;
            @(negedge clk); #1;
        end
        check("bf_idle", db_o[7], 0);
        a = db_o[6:0];
        @(negedge clk); en = 0; rw = 0;
        @(posedge clk);
    endtask

    task automatic do_instr(input logic [7:0] d);
        int n;
        logic [6:0] a;
        bus_write(0, d);
        m_instr(d);
        wait_idle(n, a);
        check($sformatf("bf_cycles_i%02h", d), n, (d == 8'h01) ? 85 : 4);
        check($sformatf("ac_i%02h", d), a, m_ac);
        check($sformatf("mode_i%02h", d), dut_mode(), m_mode());
    endtask

    task automatic do_data_wr(input logic [7:0] d);
        int n;
        logic [6:0] a;
        bus_write(1, d);
        m_data_wr(d);
        wait_idle(n, a);
        check($sformatf("bf_cycles_d%02h", d), n, 4);
        check($sformatf("ac_d%02h", d), a, m_ac);
    endtask

    task automatic do_data_rd();
        logic [7:0] got;
        logic [7:0] exp;
        bit ok;
        int n;
        logic [6:0] a;
        ok = 1;
        if (m_cgsel) begin
`ifdef LCD1602_CGRAM_EN
            exp = m_cg[m_ac]; ok = m_cg_ok[m_ac];
`else
            exp = 8'h00;
`endif
        end else begin
            exp = m_dd[m_ac]; ok = m_dd_ok[m_ac];
        end
        bus_read(1, got);
        if (ok)
            check($sformatf("rd_ac%02h", m_ac), got, exp);
        m_step(m_id);
        wait_idle(n, a);
        check("ac_after_rd", a, m_ac);
    endtask

    task automatic screen_check(input string tag);
        int ad;
        for (int ra = 0; ra < 32; ra++) begin
            ad = (ra < 16) ? ra : 'h40 + ra - 16;
            @(negedge clk); rd_addr = 5'(ra);
            @(negedge clk); #1;
            if (m_dd_ok[ad])
                check($sformatf("%s_scr%0d", tag, ra), rd_data, m_dd[ad]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0; en = 1; rw = 1; rs = 0;
        @(negedge clk); #1 check("db_oe_rst", db_oe, 0);
        @(negedge clk); en = 0; rw = 0; rst_n = 1;
        m_reset();
        #1;
        check("mode_rst", dut_mode(), m_mode());
        check("err_rst", err_busy, m_err);
    endtask

    initial begin
        logic [7:0] v;
        int n;
        logic [6:0] a;
        rst_n = 0; en = 0; rs = 0; rw = 0; db_i = 0; rd_addr = 0;
        for (int k = 0; k < 128; k++) m_dd_ok[k] = 0;
        for (int k = 0; k < 64; k++) m_cg_ok[k] = 0;
        m_reset();
        do_reset();

        bus_read(0, v);
        check("bf_poll_rst", v, 8'h00);

        do_instr(8'h01);
        screen_check("clear");

        do_instr(8'h80);
        do_data_wr(8'h41);
        do_data_wr(8'h42);
        screen_check("hello");

        do_instr(8'hA7);
        do_data_wr(8'h55);
        do_data_wr(8'h66);
        screen_check("wrap");
        do_instr(8'hA7);
        do_data_rd();
        do_data_rd();

        do_instr(8'h04);
        do_instr(8'h80);
        do_data_wr(8'h77);
        do_instr(8'hC0);
        do_data_wr(8'h78);
        do_instr(8'h06);
        do_instr(8'hB5);
        do_instr(8'hF0);

        do_instr(8'h48);
        do_data_wr(8'h1F);
        do_instr(8'h48);
        do_data_rd();

        // write landing on the last BUSY cycle is refused
        do_instr(8'h80);
        bus_write(1, 8'h31);
        m_data_wr(8'h31);
        @(posedge clk);
        @(posedge clk);
        bus_write(1, 8'h32);
        m_err = 1;
        wait_idle(n, a);
        check("ac_lastbusy", a, m_ac);
        check("err_lastbusy", err_busy, m_err);
        screen_check("lastbusy");

        do_reset();

        do_instr(8'h80);
        bus_write(1, 8'hC3);
        m_data_wr(8'hC3);
        bus_write(1, 8'hC4);
        m_err = 1;
        wait_idle(n, a);
        check("ac_busywr", a, m_ac);
        check("err_busywr", err_busy, m_err);

        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 4) do_instr(8'($urandom_range(0, 255)));
            else if (k < 8) do_data_wr(8'($urandom_range(0, 255)));
            else do_data_rd();
        end
        check("err_sticky", err_busy, m_err);
        screen_check("rand");

        // reset while the clear fill is still running
        do_instr(8'h8F);
        do_data_wr(8'hA5);
        bus_write(0, 8'h01);
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 0; rs = 0;
        @(negedge clk); #1;
        check("bf_clr_abort", db_o[7], 0);
        rst_n = 1;
        m_reset();
        for (int k = 0; k < 128; k++)
            if (k != 'h0F) m_dd_ok[k] = 0;
        m_dd[0] = 8'h20; m_dd_ok[0] = 1;
        wait_idle(n, a);
        check("bf_cycles_abort", n, 0);
        check("ac_abort", a, 0);
        check("err_abort", err_busy, m_err);
        screen_check("abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd1602_emu.md
LCD1602_EMU -- requirements
Module: lcd1602_emu

Interface
REQ-001 SHALL have parameter BUSY_CYC, default 4: busy-flag hold cycles after each accepted write.
REQ-002 SHALL have port clk, input, 1: single clock; the only clock.
REQ-003 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-004 SHALL have ports rs, rw and en, input, 1 each: LCD bus register select, read/write and enable from the host.
REQ-005 SHALL have port db_i, input, 8: DB bus value driven by the host.
REQ-006 SHALL have ports db_o (output, 8) and db_oe (output, 1): DB read data and DB drive enable; the top-level tristate is DB = db_oe ? db_o : Z.
REQ-007 SHALL have port rd_addr, input, 5: screen index; 0-15 maps to DDRAM 0x00-0x0F and 16-31 maps to DDRAM 0x40-0x4F.
REQ-008 SHALL have port rd_data, output, 8: DDRAM byte at rd_addr.
REQ-009 SHALL have outputs disp_on, cursor_on, blink_on, id, sh, dl, n_lines and font, 1 bit each: current mode bits.
REQ-010 SHALL have output err_busy, 1: sticky flag, set by a write attempted while busy.

Function
REQ-011 SHALL register en, rs, rw and db_i each cycle (en_q, rs_q, rw_q, db_q) and define strobe = en_q & ~en.
REQ-012 SHALL, on strobe with rw_q=0 and state IDLE, execute db_q as an instruction (rs_q=0) or a data write (rs_q=1).
REQ-013 SHALL, on strobe with rw_q=0 and state not IDLE, ignore the cycle and set err_busy.
REQ-014 SHALL drive db_oe = en & rw combinationally, so data is valid in the same cycle EN is high.
REQ-015 SHALL drive db_o = {BF, AC[6:0]} when rs=0, and DDRAM[AC] when rs=1.
REQ-016 SHALL, on strobe with rw_q=1 and rs_q=1, step AC per the id bit; an rs_q=0 read SHALL NOT change state.
REQ-017 SHALL decode instructions by highest set bit of db_q:
- 0x01: clear; BF=1, AC=0, id=1.
- 0x02/0x03: home; AC=0.
- 0x04-07: id=b1, sh=b0.
- 0x08-0F: disp_on=b2, cursor_on=b1, blink_on=b0.
- 0x10-1F: b3=0 steps AC by b2 (1=+1, 0=-1); b3=1 is accepted and has no effect.
- 0x20-3F: dl=b4, n_lines=b3, font=b2.
- 0x40-7F: AC selects CGRAM, address db_q[5:0].
- 0x80-FF: AC=db_q[6:0] and selects DDRAM; 0x28-0x3F folds to 0x00, 0x68-0x7F folds to 0x40.
REQ-018 SHALL, on a data write, store db_q at DDRAM[AC] and then step AC.
REQ-019 SHALL wrap the DDRAM AC as follows:
- +1: 0x27->0x40, 0x67->0x00.
- -1: 0x00->0x67, 0x40->0x27.
REQ-020 SHALL map the DDRAM index as AC<0x40 ? AC : AC-0x18 (80 entries).
REQ-021 SHALL use a three-state FSM:
- IDLE: BF=0; an accepted write goes to BUSY, or to CLEAR for instruction 0x01.
- CLEAR: write 0x20 to DDRAM index 0..79, one per cycle, then go to BUSY.
- BUSY: count BUSY_CYC cycles, then go to IDLE.
REQ-022 SHALL hold BF=1 in CLEAR and BUSY; execution latency from strobe is 1 cycle, and BF rises in the cycle after the strobe.
REQ-023 SHALL give rd_data 1-cycle registered latency, and a read SHALL return the new byte if the same index was written in the previous cycle.
REQ-024 SHALL, when strobe coincides with the last BUSY cycle, treat the strobe as busy (ignored, err_busy set).

Reset
REQ-025 SHALL, on rst_n=0 at a clock edge, set FSM=IDLE, BF=0, AC=0 (DDRAM selected), id=1, dl=1 and all other mode bits=0.
REQ-026 SHALL, on the same reset, clear err_busy, en_q, rs_q and rw_q.
REQ-027 SHALL hold db_oe=0 while rst_n=0; DDRAM contents SHALL be preserved through reset.
REQ-028 SHALL, when reset is asserted mid-CLEAR, abort the fill immediately.

Configuration
REQ-029 SHALL, with macro LCD1602_CGRAM_EN defined, implement a 64x8 CGRAM: data writes and reads with CGRAM selected access CGRAM[AC[5:0]], and AC steps modulo 64.
REQ-030 SHALL, without LCD1602_CGRAM_EN, discard CGRAM data writes (BUSY is still entered), return 0x00 on CGRAM reads, and still step AC.

Structure
REQ-031 SHALL place instruction opcode masks, wrap constants (0x27, 0x40, 0x67, 0x20 fill, 80 depth) and the FSM state enum in package lcd1602_pkg.
REQ-032 SHALL place DDRAM storage in sub-module lcd1602_ddram: one write port shared by data writes and clear fill, one combinational bus-read port, and one registered rd port.

Verification
REQ-033 SHALL cover this scenario: reset, then poll BF -> db_o=0x00 when rs=0, rw=1, en=1.
REQ-034 SHALL cover: write 0x80, then data 0x41, 0x42 -> rd_addr 0/1 returns 0x41/0x42, and BF reads 1 for 4 cycles after each strobe.
REQ-035 SHALL cover: write 0xA7 then data 0x55, 0x66 -> DDRAM 0x27=0x55, 0x40=0x66, rd_addr 16=0x66.
REQ-036 SHALL cover: instruction 0x01 -> BF=1 for 81+4 cycles, all rd_addr 0-31 return 0x20, AC=0.
REQ-037 SHALL cover: data write during BUSY -> DDRAM unchanged and err_busy=1 until reset.
REQ-038 SHALL cover: with LCD1602_CGRAM_EN, write 0x48 then data 0x1F and read back -> 0x1F; without the macro the read back returns 0x00.
